// File: rtl/sap_ctrl_seq.sv
// SAP controller-sequencer: one-hot T1..T6 ring plus opcode decode into the datapath control word.
// Optional JMP (opcode 0011) is compiled in when SAP_CTRL_JMP_EN is defined.
module sap_ctrl_seq (
    input  logic       i_clk,
    input  logic       i_clr_n,
    input  logic       i_run,
    input  logic [3:0] i_opcode,
    output logic [5:0] o_t_state,
    output logic       o_halted,
    output logic       o_cp,
    output logic       o_ep,
    output logic       o_lm_n,
    output logic       o_ce_n,
    output logic       o_li_n,
    output logic       o_ei_n,
    output logic       o_la_n,
    output logic       o_ea,
    output logic       o_su,
    output logic       o_eu,
    output logic       o_lb_n,
    output logic       o_lo_n,
    output logic       o_jp
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    t_state_e r_state;
    logic     r_halted;

    // Active-high internal strobes; active-low ports are inverted at the boundary.
    logic w_live;
    logic w_cp, w_ep, w_lm, w_ce, w_li, w_ei, w_la, w_ea, w_su, w_eu, w_lb, w_lo;
`ifdef SAP_CTRL_JMP_EN
    logic w_jp;
`endif

    // Ring counter and sticky halt flag; HLT freezes the ring in T4.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state  <= T1;
            r_halted <= 1'b0;
        end else if (i_run && !r_halted) begin
            if ((r_state == T4) && (i_opcode == OP_HLT)) begin
                r_halted <= 1'b1;
            end else begin
                case (r_state)
                    T1:      r_state <= T2;
                    T2:      r_state <= T3;
                    T3:      r_state <= T4;
                    T4:      r_state <= T5;
                    T5:      r_state <= T6;
                    T6:      r_state <= T1;
                    default: r_state <= T1;
                endcase
            end
        end else begin
            r_state  <= r_state;
            r_halted <= r_halted;
        end
    end

    // Gating with clr_n makes the word inactive the instant reset asserts.
    assign w_live = i_clr_n & i_run & ~r_halted;

    // Control word decode from ring state and opcode.
    always_comb begin
        w_cp = 1'b0; w_ep = 1'b0; w_lm = 1'b0; w_ce = 1'b0;
        w_li = 1'b0; w_ei = 1'b0; w_la = 1'b0; w_ea = 1'b0;
        w_su = 1'b0; w_eu = 1'b0; w_lb = 1'b0; w_lo = 1'b0;
`ifdef SAP_CTRL_JMP_EN
        w_jp = 1'b0;
`endif
        if (w_live) begin
            case (r_state)
                T1: begin w_ep = 1'b1; w_lm = 1'b1; end
                T2: begin w_cp = 1'b1; end
                T3: begin w_ce = 1'b1; w_li = 1'b1; end
                T4: begin
                    case (i_opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin w_ei = 1'b1; w_lm = 1'b1; end
                        OP_OUT:                 begin w_ea = 1'b1; w_lo = 1'b1; end
`ifdef SAP_CTRL_JMP_EN
                        OP_JMP:                 begin w_ei = 1'b1; w_jp = 1'b1; end
`endif
                        default:                begin w_ei = 1'b0; end
                    endcase
                end
                T5: begin
                    case (i_opcode)
                        OP_LDA:         begin w_ce = 1'b1; w_la = 1'b1; end
                        OP_ADD, OP_SUB: begin w_ce = 1'b1; w_lb = 1'b1; w_su = (i_opcode == OP_SUB); end
                        default:        begin w_ce = 1'b0; end
                    endcase
                end
                T6: begin
                    case (i_opcode)
                        OP_ADD, OP_SUB: begin w_eu = 1'b1; w_la = 1'b1; w_su = (i_opcode == OP_SUB); end
                        default:        begin w_eu = 1'b0; end
                    endcase
                end
                default: begin w_ep = 1'b0; end
            endcase
        end else begin
            w_ep = 1'b0;
        end
    end

    assign o_t_state = r_state;
    assign o_halted  = r_halted;
    assign o_cp      = w_cp;
    assign o_ep      = w_ep;
    assign o_lm_n    = ~w_lm;
    assign o_ce_n    = ~w_ce;
    assign o_li_n    = ~w_li;
    assign o_ei_n    = ~w_ei;
    assign o_la_n    = ~w_la;
    assign o_ea      = w_ea;
    assign o_su      = w_su;
    assign o_eu      = w_eu;
    assign o_lb_n    = ~w_lb;
    assign o_lo_n    = ~w_lo;
`ifdef SAP_CTRL_JMP_EN
    assign o_jp      = w_jp;
`else
    assign o_jp      = 1'b0;
`endif

endmodule
